// File: rtl/niosii_system_sysid_checker.sv
// rtl/niosii_system_sysid_checker.sv - reads the system ID and timestamp words over Avalon-MM and compares them
//
// Ports:
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   start                   : one-cycle pulse requesting a new check (honoured in DONE only)
//   avm_address/avm_read    : Avalon-MM read command (address 0 = ID word, 1 = timestamp word)
//   avm_waitrequest         : slave stall, command accepted when read=1 and waitrequest=0
//   avm_readdata/_valid     : read response
//   busy/done/pass          : check status; pass is meaningful while done=1
//   id_mismatch/ts_mismatch : per-word compare result
//   timeout                 : check abandoned after all retries expired
//   read_id/read_ts         : last captured words
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0,
  parameter logic [31:0] EXPECTED_TS    = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS, S_CHECK, S_DONE
  } state_e;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  RETRY_LIM = 5'(RETRY_MAX);

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [4:0]  retry_q, retry_d;
  logic        gap_q, gap_d;
  logic        pass_q, pass_d;
  logic        id_mm_q, id_mm_d;
  logic        ts_mm_q, ts_mm_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [31:0] read_id_q, read_id_d;
  logic [31:0] read_ts_q, read_ts_d;

  logic in_rd, in_wt, accepted, progress, expired;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      retry_q    <= '0;
      gap_q      <= 1'b0;
      pass_q     <= 1'b0;
      id_mm_q    <= 1'b0;
      ts_mm_q    <= 1'b0;
      tmo_flag_q <= 1'b0;
      read_id_q  <= '0;
      read_ts_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      pass_q     <= pass_d;
      id_mm_q    <= id_mm_d;
      ts_mm_q    <= ts_mm_d;
      tmo_flag_q <= tmo_flag_d;
      read_id_q  <= read_id_d;
      read_ts_q  <= read_ts_d;
    end
  end

  always_comb begin
    in_rd    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    in_wt    = (state_q == S_WT_ID) || (state_q == S_WT_TS);
    // gap_q forces one idle cycle on re-issue so the retry is a fresh command
    avm_read    = in_rd && !gap_q;
    avm_address = (state_q == S_RD_TS);
    accepted    = avm_read && !avm_waitrequest;
    progress    = (in_rd && accepted) || (in_wt && avm_readdatavalid);
    expired     = (in_rd || in_wt) && (tmo_q == TMO_LAST);

    state_d    = state_q;
    tmo_d      = (in_rd || in_wt) ? tmo_q + 16'd1 : 16'd0;
    retry_d    = retry_q;
    gap_d      = 1'b0;
    pass_d     = pass_q;
    id_mm_d    = id_mm_q;
    ts_mm_d    = ts_mm_q;
    tmo_flag_d = tmo_flag_q;
    read_id_d  = read_id_q;
    read_ts_d  = read_ts_q;

    case (state_q)
      S_IDLE: begin
        // only reachable through reset, so leaving at once is the auto-start
        state_d = S_RD_ID;
        tmo_d   = '0;
        retry_d = '0;
      end
      S_RD_ID: if (accepted) state_d = S_WT_ID;
      S_WT_ID: if (avm_readdatavalid) begin
        read_id_d = avm_readdata;
        state_d   = S_RD_TS;
        tmo_d     = '0;
      end
      S_RD_TS: if (accepted) state_d = S_WT_TS;
      S_WT_TS: if (avm_readdatavalid) begin
        read_ts_d = avm_readdata;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        id_mm_d = (read_id_q != EXPECTED_ID);
        ts_mm_d = (read_ts_q != EXPECTED_TS);
        pass_d  = (read_id_q == EXPECTED_ID) && (read_ts_q == EXPECTED_TS);
        state_d = S_DONE;
      end
      S_DONE: if (start) begin
        state_d    = S_RD_ID;
        tmo_d      = '0;
        retry_d    = '0;
        pass_d     = 1'b0;
        id_mm_d    = 1'b0;
        ts_mm_d    = 1'b0;
        tmo_flag_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // a transaction completing on its final cycle wins over the timeout
    if (expired && !progress) begin
      retry_d = retry_q + 5'd1;
      tmo_d   = '0;
      if (retry_q == RETRY_LIM) begin
        state_d    = S_DONE;
        tmo_flag_d = 1'b1;
        pass_d     = 1'b0;
      end else begin
        state_d = ((state_q == S_RD_ID) || (state_q == S_WT_ID)) ? S_RD_ID : S_RD_TS;
        gap_d   = 1'b1;
      end
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = tmo_flag_q;
  assign read_id     = read_id_q;
  assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb/tb_niosii_system_sysid_checker.sv - directed self-checking bench for niosii_system_sysid_checker
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h58D6_27E9;
  localparam logic [31:0] EXP_TS = 32'h6489_ABCD;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] read_id, read_ts;

  int n_tests = 0;
  int n_fail  = 0;

  // slave configuration
  int          stall_cycles = 0;
  logic [1:0]  resp_mask = 2'b11;
  logic [31:0] id_val = EXP_ID;
  logic [31:0] ts_val = EXP_TS;
  logic        late_rdv = 1'b0;
  logic [31:0] late_data = 32'hDEAD_BEEF;

  // slave observation
  int id_issues = 0, ts_issues = 0, accepts = 0, ts_accepts = 0, stab_err = 0;
  logic        pend = 1'b0, prev_read = 1'b0, prev_addr = 1'b0, prev_stall = 1'b0;
  logic [31:0] pend_data = '0;
  int          stall_cnt = 0;

  niosii_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(8), .RETRY_MAX(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch), .timeout(timeout), .read_id(read_id), .read_ts(read_ts)
  );

  always #5 clock = ~clock;

  // Avalon slave: decides waitrequest/response for each cycle at the falling edge
  always @(negedge clock) begin
    if (!reset_n) begin
      pend = 1'b0; prev_read = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = late_rdv;
      avm_readdata = late_rdv ? late_data : 32'h0;
    end else begin
      avm_readdatavalid = pend || late_rdv;
      avm_readdata = late_rdv ? late_data : pend_data;
      pend = 1'b0;
      if (prev_stall && (!avm_read || avm_address != prev_addr)) stab_err++;
      if (avm_read && !prev_read) begin
        if (avm_address) ts_issues++; else id_issues++;
      end
      prev_read = avm_read;
      prev_addr = avm_address;
      if (avm_read) begin
        if (stall_cnt < stall_cycles) begin
          avm_waitrequest = 1'b1; stall_cnt++; prev_stall = 1'b1;
        end else begin
          avm_waitrequest = 1'b0; stall_cnt = 0; prev_stall = 1'b0;
          accepts++;
          if (avm_address) ts_accepts++;
          if (resp_mask[avm_address]) begin
            pend = 1'b1;
            pend_data = avm_address ? ts_val : id_val;
          end
        end
      end else begin
        avm_waitrequest = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_id, b_ts, b_acc, b_err, n;

    tick(); tick();
    check("rst_read", {31'd0, avm_read}, 0);
    check("rst_addr", {31'd0, avm_address}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_read_id", read_id, 0);

    // auto-start after reset release
    reset_n = 1'b1;
    tick();
    check("auto_read", {31'd0, avm_read}, 1);
    check("auto_addr", {31'd0, avm_address}, 0);
    check("auto_busy", {31'd0, busy}, 1);
    wait_done(40);
    check("good_pass", {31'd0, pass}, 1);
    check("good_id_mm", {31'd0, id_mismatch}, 0);
    check("good_ts_mm", {31'd0, ts_mismatch}, 0);
    check("good_read_id", read_id, EXP_ID);
    check("good_read_ts", read_ts, EXP_TS);

    // six-cycle latency from start to done
    pulse_start();
    check("lat_busy_c1", {31'd0, busy}, 1);
    check("lat_done_c1", {31'd0, done}, 0);
    for (int i = 2; i <= 5; i++) tick();
    check("lat_done_c5", {31'd0, done}, 0);
    tick();
    check("lat_done_c6", {31'd0, done}, 1);
    check("lat_pass", {31'd0, pass}, 1);

    // ID word wrong
    id_val = 32'h0;
    pulse_start();
    wait_done(40);
    check("badid_pass", {31'd0, pass}, 0);
    check("badid_id_mm", {31'd0, id_mismatch}, 1);
    check("badid_ts_mm", {31'd0, ts_mismatch}, 0);
    check("badid_read_id", read_id, 32'h0);

    // start in DONE clears flags; start while busy is ignored
    id_val = EXP_ID;
    b_id = id_issues; b_ts = ts_issues;
    pulse_start();
    check("restart_id_mm_clr", {31'd0, id_mismatch}, 0);
    check("restart_done_clr", {31'd0, done}, 0);
    pulse_start();
    wait_done(40);
    check("restart_pass", {31'd0, pass}, 1);
    tick(); tick(); tick();
    check("busy_start_ignored_done", {31'd0, done}, 1);
    check("busy_start_ignored_issues", id_issues - b_id + ts_issues - b_ts, 2);

    // three-cycle stall on each command
    stall_cycles = 3;
    b_acc = accepts; b_err = stab_err; b_id = id_issues; b_ts = ts_issues;
    pulse_start();
    wait_done(60);
    check("stall_pass", {31'd0, pass}, 1);
    check("stall_accepts", accepts - b_acc, 2);
    check("stall_stability", stab_err - b_err, 0);
    check("stall_issues", id_issues - b_id + ts_issues - b_ts, 2);
    stall_cycles = 0;

    // no response ever: 1 issue + 2 retries, then give up
    resp_mask = 2'b00;
    b_id = id_issues; b_ts = ts_issues;
    pulse_start();
    wait_done(200);
    check("tmo_flag", {31'd0, timeout}, 1);
    check("tmo_pass", {31'd0, pass}, 0);
    check("tmo_id_issues", id_issues - b_id, 3);
    check("tmo_ts_issues", ts_issues - b_ts, 0);
    check("tmo_read_id_kept", read_id, EXP_ID);

    // reset during WT_TS followed by a late response
    resp_mask = 2'b01;
    b_ts = ts_accepts;
    pulse_start();
    n = 0;
    while (ts_accepts == b_ts && n < 40) begin
      tick();
      n++;
    end
    check("wt_ts_reached", ts_accepts - b_ts, 1);
    tick();
    check("wt_ts_busy", {31'd0, busy}, 1);
    resp_mask = 2'b11;
    reset_n = 1'b0;
    late_rdv = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_timeout", {31'd0, timeout}, 0);
    check("midrst_read_id", read_id, 0);
    check("midrst_read_ts", read_ts, 0);
    tick();
    reset_n = 1'b1;
    late_rdv = 1'b0;
    tick();
    check("late_read_ts", read_ts, 0);
    check("late_read_id", read_id, 0);
    check("late_restart_read", {31'd0, avm_read}, 1);
    check("late_restart_addr", {31'd0, avm_address}, 0);
    wait_done(40);
    check("late_final_pass", {31'd0, pass}, 1);
    check("late_final_ts", read_ts, EXP_TS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
